sd_otf_converter: RTL and testbench

- On-the-fly converter for the borrow-save (plus/minus) quotient digit stream produced by the divider datapath; it is the read end of the same 2-bit digit interface (bit1 = plus, bit0 = minus).
- Accepts one radix-2 signed digit per enabled cycle, MSD first, and maintains Q and QM = Q - 1 ulp, so the final two's-complement quotient needs no carry-propagate adder.
- Applies the final non-restoring correction (selects QM when the final remainder is negative) and presents a registered result with a one-cycle done pulse.

---
 rtl/sd_pkg.sv | 16 +
 rtl/sd_otf_step.sv | 30 +++
 rtl/sd_otf_converter.sv | 99 +++++++++
 tb/tb_sd_otf_converter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit on-the-fly converter.
//   SD_POS / SD_NEG / SD_ZERO : {plus, minus} digit encodings (2'b11 also decodes as zero)
//   sd_state_e                : converter FSM states
package sd_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FINISH  = 2'd2
  } sd_state_e;

endpackage

// File: rtl/sd_otf_step.sv
// Combinational on-the-fly conversion step for one radix-2 signed digit.
// Shifts Q and QM (= Q - 1 ulp) left by one position and appends the new digit.
//   q, qm           : current Q / QM, W bits
//   digit           : {plus, minus}; 10 = +1, 01 = -1, 00/11 = 0
//   q_next, qm_next : Q / QM after absorbing the digit (MSB shifted out is dropped)
module sd_otf_step
  import sd_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    if (digit == SD_POS) begin
      q_next  = {q[W-2:0], 1'b1};
      qm_next = {q[W-2:0], 1'b0};
    end else if (digit == SD_NEG) begin
      q_next  = {qm[W-2:0], 1'b1};
      qm_next = {qm[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sd_otf_converter.sv
// On-the-fly converter: turns an MSD-first borrow-save quotient digit stream into a
// two's-complement quotient without a carry-propagate adder, applying the final
// non-restoring correction (QM selected when the final remainder is negative).
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin (or abort and restart) a conversion
//   write_enable  : global advance; when low all state holds (except FINISH -> IDLE)
//   digit_valid   : digit_in meaningful this cycle
//   digit_in      : {plus, minus} signed digit
//   rem_neg       : final remainder sign, sampled with the last digit only
//   digit_ready   : a digit can be accepted this cycle
//   busy          : conversion in progress
//   done          : one-cycle pulse when q_out updates
//   q_out         : signed quotient, N_DIGITS+1 bits
module sd_otf_converter
  import sd_pkg::*;
#(
  parameter int N_DIGITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                write_enable,
  input  logic                digit_valid,
  input  logic [1:0]          digit_in,
  input  logic                rem_neg,
  output logic                digit_ready,
  output logic                busy,
  output logic                done,
  output logic [N_DIGITS:0]   q_out
);

  localparam int W     = N_DIGITS + 1;
  localparam int CNT_W = $clog2(N_DIGITS + 1);

  sd_state_e        state;
  logic [W-1:0]     q_reg;
  logic [W-1:0]     qm_reg;
  logic [W-1:0]     q_next;
  logic [W-1:0]     qm_next;
  logic [W-1:0]     q_out_reg;
  logic [CNT_W-1:0] cnt;
  logic             last_digit;

  sd_otf_step #(.W(W)) u_step (
    .q       (q_reg),
    .qm      (qm_reg),
    .digit   (digit_in),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  assign last_digit  = (cnt == CNT_W'(N_DIGITS - 1));
  assign busy        = (state == CONVERT);
  assign digit_ready = busy && write_enable;
  assign done        = (state == FINISH);
  assign q_out       = q_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q_reg     <= '0;
      qm_reg    <= '1;
      cnt       <= '0;
      q_out_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && write_enable) begin
            q_reg  <= '0;
            qm_reg <= '1;
            cnt    <= '0;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          if (write_enable) begin
            // Restart takes priority over a digit presented in the same cycle.
            if (start) begin
              q_reg  <= '0;
              qm_reg <= '1;
              cnt    <= '0;
            end else if (digit_valid) begin
              q_reg  <= q_next;
              qm_reg <= qm_next;
              cnt    <= cnt + CNT_W'(1);
              if (last_digit) begin
                q_out_reg <= rem_neg ? qm_next : q_next;
                state     <= FINISH;
              end
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_otf_converter.sv
// Scoreboard bench for sd_otf_converter with N_DIGITS = 8 (9-bit quotient).
module tb_sd_otf_converter;
  import sd_pkg::*;

  localparam int N = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       write_enable;
  logic       digit_valid;
  logic [1:0] digit_in;
  logic       rem_neg;
  logic       digit_ready;
  logic       busy;
  logic       done;
  logic [N:0] q_out;

  sd_otf_converter #(.N_DIGITS(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .write_enable (write_enable),
    .digit_valid  (digit_valid),
    .digit_in     (digit_in),
    .rem_neg      (rem_neg),
    .digit_ready  (digit_ready),
    .busy         (busy),
    .done         (done),
    .q_out        (q_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N:0]  q;
    int unsigned at;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse; checks the Q/QM invariant while busy.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t       e;
    logic [N:0] diff;
    if (rst_n) begin
      if (busy) begin
        diff = dut.q_reg - dut.qm_reg;
        check("inv_q_minus_qm", 32'(diff), 32'd1);
      end
      if (done) begin
        check("done_width", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 q_out=%0h expected no done", q_out);
        end else begin
          e = sb.pop_front();
          check({e.name, "_q"}, 32'(q_out), 32'(e.q));
          check({e.name, "_cycle"}, cyc, e.at);
        end
      end
    end
    prev_done = done;
  end

  task automatic do_start();
    start        = 1'b1;
    write_enable = 1'b1;
    digit_valid  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] d, input logic rn);
    digit_valid  = 1'b1;
    digit_in     = d;
    write_enable = 1'b1;
    rem_neg      = rn;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    digit_in    = SD_ZERO;
  endtask

  // write_enable low with a tempting digit on the bus: nothing may move.
  task automatic stall_we(input int n);
    write_enable = 1'b0;
    digit_valid  = 1'b1;
    digit_in     = SD_POS;
    rem_neg      = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) check("stall_we_ready", 32'(digit_ready), 32'd0);
    end
    write_enable = 1'b1;
    digit_valid  = 1'b0;
  endtask

  task automatic stall_dv(input int n);
    write_enable = 1'b1;
    digit_valid  = 1'b0;
    digit_in     = SD_NEG;
    repeat (n) begin @(posedge clk); #1; end
    digit_in = SD_ZERO;
  endtask

  // Digit i (MSD first) is digits[15-2i -: 2]. rem_neg is driven inverted on all but
  // the last digit so any early sampling is exposed.
  task automatic run_conv(input string nm, input logic [15:0] digits, input logic rn,
                          input logic [N:0] expq, input int we_after, input int we_n,
                          input int dv_after, input int dv_n);
    int unsigned s;
    exp_t e;
    do_start();
    s = cyc;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    check({nm, "_ready"}, 32'(digit_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        e.q = expq; e.at = s + N + we_n + dv_n; e.name = nm;
        sb.push_back(e);
      end
      send(digits[15-2*i -: 2], (i == N - 1) ? rn : ~rn);
      if (i == we_after) stall_we(we_n);
      if (i == dv_after) stall_dv(dv_n);
    end
    @(posedge clk); #1;
    check({nm, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned s;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; write_enable = 1'b0; digit_valid = 1'b0;
    digit_in = SD_ZERO; rem_neg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_out", 32'(q_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(digit_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_conv("all_pos",    16'hAAAA, 1'b0, 9'h0FF, -1, 0, -1, 0);
    run_conv("pos_negs",   16'h9555, 1'b0, 9'h001, -1, 0, -1, 0);
    run_conv("all_neg",    16'h5555, 1'b0, 9'h101, -1, 0, -1, 0);
    run_conv("all_neg_rn", 16'h5555, 1'b1, 9'h100, -1, 0, -1, 0);
    run_conv("mix",        16'h9002, 1'b0, 9'h041, -1, 0, -1, 0);
    run_conv("mix_rn",     16'h9002, 1'b1, 9'h040, -1, 0, -1, 0);
    run_conv("mix_z11",    16'h9302, 1'b0, 9'h041, -1, 0, -1, 0);
    run_conv("mix_stall",  16'h9002, 1'b0, 9'h041,  2, 3,  4, 2);

    // Abort after four digits; the +1 presented with the restart must be ignored.
    do_start();
    for (int i = 0; i < 4; i++) send(SD_NEG, 1'b1);
    start = 1'b1; digit_valid = 1'b1; digit_in = SD_POS; write_enable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; digit_valid = 1'b0;
    s = cyc;
    check("abort_q_hold", 32'(q_out), 32'h041);
    check("abort_busy", 32'(busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        e.q = 9'h0FF; e.at = s + N; e.name = "abort";
        sb.push_back(e);
      end
      send(SD_POS, 1'b0);
    end
    @(posedge clk); #1;

    // Async reset mid-conversion.
    do_start();
    send(SD_POS, 1'b0);
    send(SD_NEG, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_q_out", 32'(q_out), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(digit_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_q_out", 32'(q_out), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
